input_debounce_bank: RTL and testbench

//   Parametrised input block for joystick and console buttons. Each channel
//   is synchronised, debounced and edge-detected. Press/release events latch

---
 rtl/input_debounce_bank.sv | 117 +++++++++++
 tb/tb_input_debounce_bank.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_debounce_bank.sv
// Input debounce bank: per-channel 2-flop synchroniser, counter debouncer,
// press/release edge detection into sticky W1C registers, a per-channel
// interrupt mask and a registered CPU read window.
module input_debounce_bank #(
   parameter int CHANNELS   = 9,
   parameter int COUNT_BITS = 16,
   parameter int DEBOUNCE   = 27000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] pins,
   input  logic [1:0]          address,
   input  logic [CHANNELS-1:0] data_in,
   input  logic                write_enable,
   output logic [CHANNELS-1:0] data_out,
   output logic [CHANNELS-1:0] state,
   output logic                interrupt
);

   localparam logic [1:0] ADDR_STATE    = 2'd0;
   localparam logic [1:0] ADDR_PRESSED  = 2'd1;
   localparam logic [1:0] ADDR_RELEASED = 2'd2;
   localparam logic [1:0] ADDR_MASK     = 2'd3;

   // Count value on which a differing level has held long enough to be accepted.
   localparam logic [COUNT_BITS-1:0] CNT_LAST = COUNT_BITS'(DEBOUNCE - 1);

   logic [CHANNELS-1:0]   pin_pressed;
   logic [CHANNELS-1:0]   sync1_q, sync2_q;
   logic [COUNT_BITS-1:0] cnt_q [CHANNELS];
   logic [COUNT_BITS-1:0] cnt_d [CHANNELS];
   logic [CHANNELS-1:0]   state_q, state_d;
   logic [CHANNELS-1:0]   pressed_q, pressed_d;
   logic [CHANNELS-1:0]   released_q, released_d;
   logic [CHANNELS-1:0]   mask_q, mask_d;
   logic [CHANNELS-1:0]   data_out_q, data_out_d;
   logic                  irq_q, irq_d;
   logic [CHANNELS-1:0]   rise, fall;
   logic [CHANNELS-1:0]   clr_pressed, clr_released;

   // Normalise polarity so that 1 always means "pressed" from here on.
   assign pin_pressed = pins ^ {CHANNELS{ACTIVE_LOW}};

   // Debounce: count consecutive cycles the synchronised level disagrees with
   // the accepted state; accept it once the count reaches DEBOUNCE-1.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so no latch is inferred.
      state_d = state_q;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != state_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               state_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + COUNT_BITS'(1);
            end
         end
      end
   end

   // Event, W1C, mask, read-mux and interrupt next-state logic.
   always_comb begin
      rise         = state_d & ~state_q;
      fall         = ~state_d & state_q;
      clr_pressed  = (write_enable && address == ADDR_PRESSED)  ? data_in : '0;
      clr_released = (write_enable && address == ADDR_RELEASED) ? data_in : '0;
      // A new event in the same cycle as its clear leaves the bit set.
      pressed_d    = (pressed_q  & ~clr_pressed)  | rise;
      released_d   = (released_q & ~clr_released) | fall;
      mask_d       = (write_enable && address == ADDR_MASK) ? data_in : mask_q;
      // Reads see the pre-write register contents.
      case (address)
         ADDR_STATE:    data_out_d = state_q;
         ADDR_PRESSED:  data_out_d = pressed_q;
         ADDR_RELEASED: data_out_d = released_q;
         default:       data_out_d = mask_q;
      endcase
      irq_d = |((pressed_q | released_q) & mask_q);
   end

   // All state registers, with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         state_q    <= '0;
         pressed_q  <= '0;
         released_q <= '0;
         mask_q     <= '0;
         data_out_q <= '0;
         irq_q      <= 1'b0;
         // NOTE: the counter array is reset too, so a partial debounce never survives reset.
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q    <= pin_pressed;
         sync2_q    <= sync1_q;
         state_q    <= state_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
         mask_q     <= mask_d;
         data_out_q <= data_out_d;
         irq_q      <= irq_d;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign state     = state_q;
   assign data_out  = data_out_q;
   assign interrupt = irq_q;

endmodule

// File: tb/tb_input_debounce_bank.sv
// Self-checking bench for input_debounce_bank: directed scenarios with literal
// expectations, then randomized pins/writes/resets compared every cycle
// against a window-based behavioural model.
module tb_input_debounce_bank;

   localparam int CH = 9;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [CH-1:0] pins;
   logic [1:0]    address;
   logic [CH-1:0] data_in;
   logic          write_enable;
   logic [CH-1:0] data_out;
   logic [CH-1:0] state;
   logic          interrupt;

   int n_tests = 0;
   int n_fail  = 0;

   input_debounce_bank #(
      .CHANNELS  (CH),
      .COUNT_BITS(16),
      .DEBOUNCE  (D),
      .ACTIVE_LOW(1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pins        (pins),
      .address     (address),
      .data_in     (data_in),
      .write_enable(write_enable),
      .data_out    (data_out),
      .state       (state),
      .interrupt   (interrupt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   // A channel's accepted level flips when the synchronised (2-edge delayed)
   // pressed level has disagreed with it on each of the last D edges, and at
   // least D edges have passed since reset or since its previous flip.
   logic [CH-1:0] m_state, m_pr, m_rl, m_mask, m_dout;
   logic          m_irq;
   logic [CH-1:0] ph [0:D];   // ph[k] = pressed level sampled k+1 edges ago
   int            age [CH];
   bit            m_valid = 1'b0;

   always @(posedge clk) begin : model
      logic [CH-1:0] nstate, clr_p, clr_r;
      bit            all_diff;
      if (!reset) begin
         m_state = '0; m_pr = '0; m_rl = '0; m_mask = '0; m_dout = '0; m_irq = 1'b0;
         for (int k = 0; k <= D; k++) ph[k] = '0;
         for (int c = 0; c < CH; c++) age[c] = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         case (address)
            2'd0:    m_dout = m_state;
            2'd1:    m_dout = m_pr;
            2'd2:    m_dout = m_rl;
            default: m_dout = m_mask;
         endcase
         m_irq  = |((m_pr | m_rl) & m_mask);
         nstate = m_state;
         for (int c = 0; c < CH; c++) begin
            all_diff = 1'b1;
            if (age[c] < D) age[c]++;
            for (int j = 0; j < D; j++) begin
               if (ph[1+j][c] == m_state[c]) all_diff = 1'b0;
            end
            if (age[c] >= D && all_diff) begin
               nstate[c] = ~m_state[c];
               age[c]    = 0;
            end
         end
         clr_p  = (write_enable && address == 2'd1) ? data_in : '0;
         clr_r  = (write_enable && address == 2'd2) ? data_in : '0;
         m_pr   = (m_pr & ~clr_p) | (nstate & ~m_state);
         m_rl   = (m_rl & ~clr_r) | (~nstate & m_state);
         if (write_enable && address == 2'd3) m_mask = data_in;
         m_state = nstate;
         for (int k = D; k > 0; k--) ph[k] = ph[k-1];
         ph[0] = ~pins;
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         check("model_state", 32'(state), 32'(m_state));
         check("model_data_out", 32'(data_out), 32'(m_dout));
         check("model_interrupt", 32'(interrupt), 32'(m_irq));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset        = 1'b0;
      pins         = '1;
      address      = 2'd0;
      data_in      = '0;
      write_enable = 1'b0;
      step(3);
      reset = 1'b1;

      // Reset with all pins released: everything stays quiet.
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("reset_state", 32'(state), 32'h0);
         check("reset_data_out", 32'(data_out), 32'h0);
         check("reset_interrupt", 32'(interrupt), 32'h0);
      end

      // Glitch of 3 cycles on ch3 is rejected.
      pins[3] = 1'b0;
      step(3);
      pins[3] = 1'b1;
      step(10);
      check("glitch_state", 32'(state), 32'h000);
      address = 2'd1;
      step(1);
      check("glitch_pressed", 32'(data_out), 32'h000);

      // Clean press on ch0: state rises exactly 6 cycles later.
      pins[0] = 1'b0;
      step(5);
      check("press_latency_early", 32'(state[0]), 32'h0);
      step(1);
      check("press_latency_exact", 32'(state[0]), 32'h1);
      address = 2'd1;
      step(1);
      check("press_pressed_read", 32'(data_out), 32'h001);

      // Clear PRESSED, release ch0, clear RELEASED.
      address = 2'd1; data_in = 9'h001; write_enable = 1'b1;
      step(1);
      write_enable = 1'b0;
      pins[0] = 1'b1;
      step(8);
      check("release_state", 32'(state), 32'h000);
      address = 2'd2; data_in = 9'h001; write_enable = 1'b1;
      step(1);
      write_enable = 1'b0; address = 2'd1;
      step(1);
      check("w1c_pressed_read", 32'(data_out), 32'h000);
      address = 2'd2;
      step(1);
      check("w1c_released_read", 32'(data_out), 32'h000);

      // Masked interrupt on ch0 press.
      address = 2'd3; data_in = 9'h001; write_enable = 1'b1;
      step(1);
      write_enable = 1'b0;
      step(1);
      check("mask_read", 32'(data_out), 32'h001);
      pins[0] = 1'b0;
      step(6);
      check("irq_same_cycle_as_event", 32'(interrupt), 32'h0);
      step(1);
      check("irq_asserted", 32'(interrupt), 32'h1);
      address = 2'd1; data_in = 9'h001; write_enable = 1'b1;
      step(1);
      write_enable = 1'b0;
      check("irq_still_high_after_clear_edge", 32'(interrupt), 32'h1);
      step(1);
      check("irq_dropped", 32'(interrupt), 32'h0);
      check("pressed_cleared", 32'(data_out), 32'h000);

      // Release edge coincides with W1C of RELEASED[0]: set wins.
      pins[0] = 1'b1;
      step(5);
      address = 2'd2; data_in = 9'h001; write_enable = 1'b1;
      step(1);
      write_enable = 1'b0;
      check("release_state_fell", 32'(state[0]), 32'h0);
      step(1);
      check("set_wins_over_w1c", 32'(data_out), 32'h001);
      check("set_wins_irq", 32'(interrupt), 32'h1);
      write_enable = 1'b1;
      step(1);
      write_enable = 1'b0;
      step(1);
      check("released_cleared", 32'(data_out), 32'h000);

      // Reset two counts into a debounce on ch5 restarts the count.
      pins[5] = 1'b0;
      step(4);
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      check("reset_mid_debounce_state", 32'(state), 32'h000);
      step(5);
      check("restart_early", 32'(state), 32'h000);
      step(1);
      check("restart_exact", 32'(state), 32'h020);

      // Randomized traffic, checked every cycle by the model comparison.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(9) == 0) pins[c] = ~pins[c];
         end
         write_enable = ($urandom_range(3) == 0);
         address      = 2'($urandom_range(3));
         data_in      = CH'($urandom);
         reset        = ($urandom_range(499) != 0);
         step(1);
      end
      reset = 1'b1;
      write_enable = 1'b0;
      step(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
